// File: rtl/seed_path_extract.sv
// seed_path_extract: copies the sibling seeds along each repetition's leaf-to-root path into the signature path buffer
module seed_path_extract #(
  parameter PARAMETER_SET = "L1",
  parameter int LAMBDA = (PARAMETER_SET == "L5") ? 256 : (PARAMETER_SET == "L3") ? 192 : 128,
  parameter int TAU = 17,
  parameter int D_HYPERCUBE = 8,
  parameter int W = LAMBDA / 32,
  parameter int SEED_AW = $clog2(TAU * (2 ** (D_HYPERCUBE + 1)) * W),
  parameter int PATH_AW = $clog2(TAU * D_HYPERCUBE * W)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_done,
  output logic [$clog2(TAU)-1:0]   o_i_star_addr,
  output logic                     o_i_star_rd_en,
  input  logic [7:0]               i_i_star,
  output logic [SEED_AW-1:0]       o_seed_addr,
  output logic                     o_seed_rd_en,
  input  logic [31:0]              i_seed,
  output logic [PATH_AW-1:0]       o_path_addr,
  output logic                     o_path_wr_en,
  output logic [31:0]              o_path
);
  localparam int D = D_HYPERCUBE;
  localparam int IAW = $clog2(TAU);
  localparam int LW = $clog2(D) + 1;
  localparam int WW = $clog2(W) + 1;
  localparam logic [SEED_AW-1:0] REP_STRIDE = SEED_AW'((2 ** (D + 1)) * W);

  typedef enum logic [2:0] {IDLE, RD_ISTAR, LD_ISTAR, COPY, DRAIN, DONE} state_t;

  state_t               state;
  logic [SEED_AW-1:0]   rep_base;
  logic [D-1:0]         node;
  logic [LW-1:0]        lvl;
  logic [WW-1:0]        w;
  logic [D:0]           leaf_sib;

  // node index times W as a fixed shift-and-add network
  function automatic logic [SEED_AW-1:0] times_w(input logic [D:0] s);
    logic [SEED_AW-1:0] acc;
    acc = '0;
    for (int k = 0; k < 32; k++)
      if (((W >> k) & 1) == 1) acc = acc + (SEED_AW'(s) << k);
    return acc;
  endfunction

  assign leaf_sib = {1'b1, i_i_star[D-1:1], ~i_i_star[0]};
  assign o_path = o_path_wr_en ? i_seed : '0;

  // control FSM: path writes trail seed reads by one cycle, path address just counts writes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_done <= 1'b0;
      o_i_star_addr <= '0;
      o_i_star_rd_en <= 1'b0;
      o_seed_addr <= '0;
      o_seed_rd_en <= 1'b0;
      o_path_addr <= '0;
      o_path_wr_en <= 1'b0;
      rep_base <= '0;
      node <= '0;
      lvl <= '0;
      w <= '0;
    end else begin
      o_done <= 1'b0;
      o_path_wr_en <= o_seed_rd_en;
      if (o_path_wr_en) o_path_addr <= o_path_addr + 1'b1;
      case (state)
        IDLE: if (i_start) begin
          state <= RD_ISTAR;
          o_i_star_addr <= '0;
          o_i_star_rd_en <= 1'b1;
          rep_base <= '0;
          o_path_addr <= '0;
        end
        RD_ISTAR: begin
          o_i_star_rd_en <= 1'b0;
          state <= LD_ISTAR;
        end
        LD_ISTAR: begin
          node <= {1'b1, i_i_star[D-1:1]};
          lvl <= '0;
          w <= '0;
          o_seed_addr <= rep_base + times_w(leaf_sib);
          o_seed_rd_en <= 1'b1;
          state <= COPY;
        end
        COPY: if (w == WW'(W - 1)) begin
          o_seed_rd_en <= 1'b0;
          state <= DRAIN;
        end else begin
          w <= w + 1'b1;
          o_seed_addr <= o_seed_addr + 1'b1;
        end
        DRAIN: if (lvl == LW'(D - 1)) begin
          if (o_i_star_addr == IAW'(TAU - 1)) begin
            o_done <= 1'b1;
            state <= DONE;
          end else begin
            o_i_star_addr <= o_i_star_addr + 1'b1;
            o_i_star_rd_en <= 1'b1;
            rep_base <= rep_base + REP_STRIDE;
            state <= RD_ISTAR;
          end
        end else begin
          lvl <= lvl + 1'b1;
          w <= '0;
          node <= node >> 1;
          o_seed_addr <= rep_base + times_w({1'b0, node} ^ (D + 1)'(1));
          o_seed_rd_en <= 1'b1;
          state <= COPY;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seed_path_extract.sv
// tb_seed_path_extract: directed checks of seed_path_extract for L1 and L5 with seed memory holding word = address
module tb_seed_path_extract;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s1 = 1'b0, done1, istar_rd1, seed_rd1, path_wr1;
  logic [4:0]  istar_addr1;
  logic [7:0]  istar_q1 = '0;
  logic [15:0] seed_addr1;
  logic [31:0] seed_q1 = '0, path_d1;
  logic [9:0]  path_addr1;

  logic        s5 = 1'b0, done5, istar_rd5, seed_rd5, path_wr5;
  logic [4:0]  istar_addr5;
  logic [7:0]  istar_q5 = '0;
  logic [16:0] seed_addr5;
  logic [31:0] seed_q5 = '0, path_d5;
  logic [10:0] path_addr5;

  logic [7:0]  istar_mem1 [0:31];
  logic [7:0]  istar_mem5 [0:31];
  logic [31:0] pbuf1 [0:1023];
  logic [31:0] pbuf5 [0:2047];

  int cmp = 0, bad = 0;
  int wc1 = 0, dc1 = 0, rwb1 = 0, wc5 = 0, dc5 = 0, rwb5 = 0;
  logic        prd_en1 = 1'b0, prd_en5 = 1'b0;
  logic [16:0] prd1 = '0, prd5 = '0;

  int sib_zero [8] = '{257, 129, 65, 33, 17, 9, 5, 3};
  int sib_ff   [8] = '{510, 254, 126, 62, 30, 14, 6, 2};
  int sib_a5   [8] = '{420, 211, 104, 53, 27, 12, 7, 2};

  seed_path_extract #(.PARAMETER_SET("L1")) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(s1), .o_done(done1),
    .o_i_star_addr(istar_addr1), .o_i_star_rd_en(istar_rd1), .i_i_star(istar_q1),
    .o_seed_addr(seed_addr1), .o_seed_rd_en(seed_rd1), .i_seed(seed_q1),
    .o_path_addr(path_addr1), .o_path_wr_en(path_wr1), .o_path(path_d1)
  );

  seed_path_extract #(.PARAMETER_SET("L5")) u5 (
    .i_clk(clk), .i_rst(rst), .i_start(s5), .o_done(done5),
    .o_i_star_addr(istar_addr5), .o_i_star_rd_en(istar_rd5), .i_i_star(istar_q5),
    .o_seed_addr(seed_addr5), .o_seed_rd_en(seed_rd5), .i_seed(seed_q5),
    .o_path_addr(path_addr5), .o_path_wr_en(path_wr5), .o_path(path_d5)
  );

  // one-cycle-latency memories; every seed word holds its own address
  always @(posedge clk) begin
    if (istar_rd1) istar_q1 <= istar_mem1[istar_addr1];
    if (seed_rd1) seed_q1 <= 32'(seed_addr1);
    if (istar_rd5) istar_q5 <= istar_mem5[istar_addr5];
    if (seed_rd5) seed_q5 <= 32'(seed_addr5);
  end

  // capture path writes and confirm each carries the word read one cycle earlier
  always @(negedge clk) begin
    if (path_wr1) begin
      pbuf1[path_addr1] = path_d1;
      wc1++;
      if (!(prd_en1 && path_d1 == 32'(prd1))) rwb1++;
    end
    if (path_wr5) begin
      pbuf5[path_addr5] = path_d5;
      wc5++;
      if (!(prd_en5 && path_d5 == 32'(prd5))) rwb5++;
    end
    if (done1) dc1++;
    if (done5) dc5++;
    prd_en1 = seed_rd1;
    prd1 = 17'(seed_addr1);
    prd_en5 = seed_rd5;
    prd5 = seed_addr5;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(int e, int l, int w, int ww, int istar);
    return (e * 512 + (((256 + istar) >> l) ^ 1)) * ww + w;
  endfunction

  task automatic run1(input bit extra, output int lat);
    @(negedge clk);
    s1 = 1'b1;
    @(posedge clk);
    #1 s1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 3000) begin
      @(posedge clk);
      lat++;
      #1 s1 = extra && (lat == 100 || lat == 500);
    end
    @(posedge clk);
    lat++;
  endtask

  task automatic run5(output int lat);
    @(negedge clk);
    s5 = 1'b1;
    @(posedge clk);
    #1 s5 = 1'b0;
    lat = 0;
    while (!done5 && lat < 5000) begin
      @(posedge clk);
      lat++;
      #1;
    end
    @(posedge clk);
    lat++;
  endtask

  task automatic sweep1(input string tag);
    int nb;
    nb = 0;
    for (int e = 0; e < 17; e++)
      for (int l = 0; l < 8; l++)
        for (int w = 0; w < 4; w++)
          if (pbuf1[(e * 8 + l) * 4 + w] !== 32'(exp_addr(e, l, w, 4, int'(istar_mem1[e])))) nb++;
    chk(tag, 32'(nb), 32'd0);
  endtask

  initial begin
    int lat, w0, d0, r0;
    for (int e = 0; e < 32; e++) begin
      istar_mem1[e] = 8'(e * 37 + 11);
      istar_mem5[e] = 8'(e * 29 + 5);
    end
    istar_mem1[0] = 8'd0;
    istar_mem5[0] = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl_l1", 32'({done1, istar_rd1, seed_rd1, path_wr1, istar_addr1, path_addr1}), 32'd0);
    chk("reset_seed_addr_l1", 32'(seed_addr1), 32'd0);
    chk("reset_path_l1", path_d1, 32'd0);
    chk("reset_l5", 32'({done5, istar_rd5, seed_rd5, path_wr5, istar_addr5, seed_addr5 != 0, path_addr5, path_d5 != 0}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // abort in the middle of a COPY burst
    @(negedge clk);
    s1 = 1'b1;
    @(posedge clk);
    #1 s1 = 1'b0;
    repeat (19) @(posedge clk);
    chk("busy_before_abort", 32'(seed_rd1), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("abort_ctrl", 32'({done1, istar_rd1, seed_rd1, path_wr1, istar_addr1, path_addr1}), 32'd0);
    chk("abort_seed_addr", 32'(seed_addr1), 32'd0);
    chk("abort_path", path_d1, 32'd0);
    w0 = wc1;
    d0 = dc1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_writes", 32'(wc1 - w0), 32'd0);
    chk("abort_no_done", 32'(dc1 - d0), 32'd0);

    // full L1 run, i_star[0] = 0, extra starts while busy
    w0 = wc1;
    d0 = dc1;
    r0 = rwb1;
    run1(1'b1, lat);
    chk("l1_latency", 32'(lat), 32'd715);
    #1;
    chk("l1_done_single", 32'(done1), 32'd0);
    repeat (30) @(negedge clk);
    chk("l1_writes", 32'(wc1 - w0), 32'd544);
    chk("l1_done_count", 32'(dc1 - d0), 32'd1);
    chk("l1_rd_to_wr", 32'(rwb1 - r0), 32'd0);
    chk("l1_idle_after", 32'({seed_rd1, istar_rd1}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("zero_lvl0_word", pbuf1[k], 32'(1028 + k));
      chk("zero_lvl7_word", pbuf1[28 + k], 32'(12 + k));
    end
    for (int l = 0; l < 8; l++) chk("zero_sibling", pbuf1[l * 4] >> 2, 32'(sib_zero[l]));
    sweep1("l1_sweep_zero");

    // i_star[0] = 255
    for (int e = 0; e < 32; e++) istar_mem1[e] = 8'(e * 53 + 7);
    istar_mem1[0] = 8'd255;
    run1(1'b0, lat);
    chk("ff_latency", 32'(lat), 32'd715);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk("ff_lvl0_word", pbuf1[k], 32'(2040 + k));
    for (int l = 0; l < 8; l++) chk("ff_sibling", pbuf1[l * 4] >> 2, 32'(sib_ff[l]));
    sweep1("l1_sweep_ff");

    // i_star[0] = 0xA5, i_star[1] = 0
    for (int e = 0; e < 32; e++) istar_mem1[e] = 8'(e * 91 + 3);
    istar_mem1[0] = 8'hA5;
    istar_mem1[1] = 8'd0;
    run1(1'b0, lat);
    chk("a5_latency", 32'(lat), 32'd715);
    repeat (3) @(negedge clk);
    for (int l = 0; l < 8; l++) chk("a5_sibling", pbuf1[l * 4] >> 2, 32'(sib_a5[l]));
    for (int k = 0; k < 4; k++) chk("e1_lvl0_word", pbuf1[32 + k], 32'(3076 + k));
    sweep1("l1_sweep_a5");

    // L5 instance: W = 8
    w0 = wc5;
    r0 = rwb5;
    d0 = dc5;
    run5(lat);
    chk("l5_latency", 32'(lat), 32'd1259);
    repeat (3) @(negedge clk);
    chk("l5_writes", 32'(wc5 - w0), 32'd1088);
    chk("l5_done_count", 32'(dc5 - d0), 32'd1);
    chk("l5_rd_to_wr", 32'(rwb5 - r0), 32'd0);
    for (int k = 0; k < 8; k++) chk("l5_lvl0_word", pbuf5[k], 32'(2056 + k));
    chk("l5_lvl7_word", pbuf5[56], 32'd24);
    chk("l5_e1_lvl0", pbuf5[64], 32'(exp_addr(1, 0, 0, 8, int'(istar_mem5[1]))));
    chk("l5_last_word", pbuf5[1087], 32'(exp_addr(16, 7, 7, 8, int'(istar_mem5[16]))));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/seed_path_extract.md
Name: seed_path_extract

Overview:
- Sits directly downstream of the view-challenge expansion stage in the signing datapath.
- For each of the TAU parallel repetitions e, it reads the hidden-party index i_star[e] from the challenge memory.
- It walks the binary seed tree of that repetition from leaf i_star[e] up to the root's children.
- It copies the LAMBDA-bit seed of every sibling node into the signature path buffer, producing the D_HYPERCUBE-node authentication path per repetition.

Parameters:
- PARAMETER_SET, "L1", selects LAMBDA and TAU ("L1"/"L3"/"L5").
- LAMBDA, 128/192/256 for L1/L3/L5, seed size in bits.
- TAU, 17, number of repetitions.
- D_HYPERCUBE, 8, tree depth; leaves = 2^D_HYPERCUBE.
- W, LAMBDA/32, 32-bit words per seed.
- SEED_AW, `CLOG2(TAU*2^(D_HYPERCUBE+1)*W), seed memory address width.
- PATH_AW, `CLOG2(TAU*D_HYPERCUBE*W), path buffer address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  single-cycle start pulse.
- o_done  out  1  single-cycle completion pulse.
- o_i_star_addr  out  `CLOG2(TAU)  challenge memory read address.
- o_i_star_rd_en  out  1  challenge memory read enable.
- i_i_star  in  8  challenge read data, valid 1 cycle after rd_en.
- o_seed_addr  out  SEED_AW  seed tree memory read address.
- o_seed_rd_en  out  1  seed memory read enable.
- i_seed  in  32  seed read data, valid 1 cycle after rd_en.
- o_path_addr  out  PATH_AW  path buffer write address.
- o_path_wr_en  out  1  path buffer write enable.
- o_path  out  32  path buffer write data.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all counters 0. Reset asserted mid-operation aborts immediately. No further reads or writes are issued, and o_done is not pulsed.
- Tree indexing (1-based heap): root = 1; node n has children 2n and 2n+1; leaves are 2^D..2^(D+1)-1.
- Leaf for repetition e = 2^D + (i_star[e] & (2^D-1)). Bits of i_star above D are ignored.
- Level loop, l = 0..D-1: sibling s = n ^ 1, then n = n >> 1. Level 0 is the leaf's sibling; level D-1 is a child of the root (2 or 3).
- Seed memory word address = (e*2^(D+1) + s)*W + w, w = 0..W-1.
- Path word address = (e*D + l)*W + w.
- Addresses are generated with running counters/adders only; no multipliers.
- FSM states:
  - IDLE: on i_start go to RD_ISTAR with e = 0. i_start is ignored in every other state.
  - RD_ISTAR: 1 cycle; rd_en = 1, addr = e.
  - LD_ISTAR: 1 cycle; latch i_i_star, form the leaf, compute the level-0 sibling.
  - COPY: W cycles. Issue seed reads w = 0..W-1 back to back. Each returned word is written to the path buffer on the following cycle, with o_path = i_seed registered-through and wr_en high for exactly W cycles per level.
  - DRAIN: 1 cycle. The last write lands here; advance l and compute the next sibling. If l < D, return to COPY; else go to NEXT_E.
  - NEXT_E: 0 cycles (merged into DRAIN). If e < TAU-1, increment e and go to RD_ISTAR; else go to DONE.
  - DONE: o_done = 1 for one cycle, then IDLE.
- Per-repetition cost: 2 + D*(W+1) cycles.
- Total latency from the i_start sampling edge to the edge where o_done is high: TAU*(2 + D*(W+1)) + 1. This is 715 cycles for L1.
- rd_en and wr_en are 0 whenever their address is not meaningful. Addresses may hold their last value when idle.
- Seed and path memories are disjoint; no read-after-write hazard is possible.

Test Plan:
- Reset mid-COPY: assert i_rst at cycle 20 after start -> all outputs 0 within the same cycle; no o_done; a fresh i_start afterwards completes normally.
- i_star[0] = 0, L1 -> siblings 257,129,65,33,17,9,5,3. Path words 0..3 come from seed addresses 1028..1031; words 28..31 come from seed addresses 12..15.
- i_star[0] = 255 -> siblings 510,254,126,62,30,14,6,2; level-0 reads at addresses 2040..2043.
- i_star[0] = 0xA5 -> siblings 420,211,104,53,27,12,7,2. For e = 1 with i_star = 0, the level-0 read address is (512+257)*4 = 3076 and the path addresses are 32..35.
- Full L1 run with a seed memory preloaded with word = address -> o_done exactly 715 cycles after start; exactly TAU*D*W = 544 writes; every o_path equals the seed address read one cycle earlier; extra i_start pulses while busy are ignored.
- Run with PARAMETER_SET = "L5" (W = 8) -> latency 17*(2+72)+1 = 1259 and 1088 writes.
